// File: rtl/amns_bram_loader.sv
// amns_bram_loader: loads the operand stream into bridge BRAM port A, starts the AMNS top, drains results.
// Optional AMNS_LOADER_CYCLE_COUNT_EN: cycles_o counts WAIT cycles (saturating); otherwise cycles_o is 0.
module amns_bram_loader #(
    parameter int s = 4,
    parameter int N = 5,
    parameter int RES_BASE = 0,
    localparam int ADDR_W = $clog2(4*N*s)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [16:0]       in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [16:0]       out_data_o,
    output logic              out_valid_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [16:0]       bram_din_o,
    input  logic [16:0]       bram_dout_i,
    output logic              amns_start_o,
    input  logic              amns_done_i,
    output logic              busy_o,
    output logic              err_o,
    output logic [31:0]       cycles_o
);
    localparam int L  = N + 3*N*s;
    localparam int NS = N*s;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0] wc, rc, pc;
    logic [1:0]        cnt;
    logic              pend, wp, rp;
    logic [16:0]       fifo_q [2];
    logic              issue, push, pop, last_pop;

    // occupancy plus in-flight read never exceeds the two FIFO slots, so a push can always land
    assign issue    = (state == DRAIN) && (rc < ADDR_W'(NS)) && ((cnt + 2'(pend)) < 2'd2);
    assign push     = pend;
    assign pop      = out_valid_o && out_ready_i;
    assign last_pop = pop && (pc == ADDR_W'(NS-1));

    assign out_valid_o = cnt != 2'd0;
    assign out_data_o  = fifo_q[rp];
    assign out_last_o  = out_valid_o && (pc == ADDR_W'(NS-1));
    assign busy_o      = state != IDLE;

    always_comb begin
        state_n      = state;
        in_ready_o   = 1'b0;
        bram_en_o    = 1'b0;
        bram_we_o    = 1'b0;
        bram_addr_o  = '0;
        bram_din_o   = '0;
        amns_start_o = 1'b0;
        case (state)
            IDLE, LOAD: begin
                in_ready_o  = 1'b1;
                bram_en_o   = in_valid_i;
                bram_we_o   = in_valid_i;
                bram_addr_o = (state == IDLE) ? '0 : wc;
                bram_din_o  = in_valid_i ? in_data_i : '0;
                if (in_valid_i)
                    state_n = (state == IDLE) ? LOAD : ((wc == ADDR_W'(L-1)) ? START : LOAD);
            end
            START: begin
                amns_start_o = 1'b1;
                state_n      = WAIT;
            end
            WAIT: state_n = amns_done_i ? DRAIN : WAIT;
            DRAIN: begin
                bram_en_o   = issue;
                bram_addr_o = issue ? ADDR_W'(RES_BASE) + rc : '0;
                if (last_pop)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            wc        <= '0;
            rc        <= '0;
            pc        <= '0;
            err_o     <= 1'b0;
            cnt       <= '0;
            pend      <= 1'b0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            state <= state_n;
            pend  <= issue;
            if (state == IDLE && in_valid_i) begin
                wc    <= ADDR_W'(1);
                err_o <= in_last_i;
            end else if (state == LOAD && in_valid_i) begin
                wc    <= wc + ADDR_W'(1);
                err_o <= err_o | (in_last_i != (wc == ADDR_W'(L-1)));
            end
            if (state == IDLE) begin
                rc <= '0;
                pc <= '0;
            end else begin
                if (issue) rc <= rc + ADDR_W'(1);
                if (pop) pc <= pc + ADDR_W'(1);
            end
            if (push) begin
                fifo_q[wp] <= bram_dout_i;
                wp         <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

`ifdef AMNS_LOADER_CYCLE_COUNT_EN
    logic [31:0] cyc;
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            cyc <= '0;
        else if (state == START)
            cyc <= '0;
        else if (state == WAIT && cyc != '1)
            cyc <= cyc + 32'd1;
    end
    assign cycles_o = cyc;
`else
    assign cycles_o = '0;
`endif
endmodule

// File: tb/tb_amns_bram_loader.sv
// tb_amns_bram_loader: table of load/drain operations against a model BRAM, plus async-reset sequences.
module tb_amns_bram_loader;
    localparam int S = 4, NN = 5, NS = 20, L = 65, AW = 7;
`ifdef AMNS_LOADER_CYCLE_COUNT_EN
    localparam bit CC = 1'b1;
`else
    localparam bit CC = 1'b0;
`endif

    logic          clock_i = 1'b0, reset_i = 1'b0;
    logic [16:0]   in_data_i = '0, out_data_o, bram_din_o, bram_dout_i = '0;
    logic          in_valid_i = 1'b0, in_last_i = 1'b0, in_ready_o;
    logic          out_valid_o, out_last_o, out_ready_i = 1'b0;
    logic          bram_en_o, bram_we_o, amns_start_o, amns_done_i = 1'b0, busy_o, err_o;
    logic [AW-1:0] bram_addr_o;
    logic [31:0]   cycles_o;

    amns_bram_loader #(.s(S), .N(NN), .RES_BASE(0)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o), .out_ready_i(out_ready_i),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
        .bram_din_o(bram_din_o), .bram_dout_i(bram_dout_i),
        .amns_start_o(amns_start_o), .amns_done_i(amns_done_i),
        .busy_o(busy_o), .err_o(err_o), .cycles_o(cycles_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        int last_pos;
        int vstall;
        int rdy;
        int dly;
        bit dis;
        int base;
    } op_t;

    int          errors = 0, checks = 0;
    logic [16:0] mem [128];
    logic [16:0] exp_q [$];
    int          wr_n = 0, wr_bad = 0, start_n = 0, rd_n = 0, pop_n = 0, max_occ = 0, cur_base = 0;
    logic        rd_q = 1'b0;
    logic [AW-1:0] rd_a = '0;

    // model BRAM port A (read data one cycle after the read) and bus monitors
    always @(negedge clock_i) begin
        if (rd_q) bram_dout_i = mem[rd_a];
        rd_q = bram_en_o && !bram_we_o;
        rd_a = bram_addr_o;
        if (bram_en_o && bram_we_o) begin
            mem[bram_addr_o] = bram_din_o;
            if (bram_addr_o != AW'(wr_n) || bram_din_o != 17'(cur_base + wr_n)) wr_bad++;
            wr_n++;
        end
        if (amns_start_o) start_n++;
        if (bram_en_o && !bram_we_o) rd_n++;
        if (rd_n - pop_n > max_occ) max_occ = rd_n - pop_n;
        if (out_valid_o && out_ready_i) pop_n++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int last_pos, input int vstall, input int base);
        int k = 0, g = 0;
        bit acc = 1'b0;
        cur_base = base; wr_n = 0; wr_bad = 0; start_n = 0; rd_n = 0; pop_n = 0; max_occ = 0;
        while (k < L && g < 3000) begin
            @(posedge clock_i); #1; g++;
            if (acc && (k == 1 || k == 21))
                chk("err_mid", 32'(err_o), 32'(last_pos >= 0 && last_pos != L-1 && last_pos <= k-1));
            in_valid_i = (vstall == 0) || ($urandom_range(99) >= vstall);
            in_data_i  = 17'(base + k);
            in_last_i  = (k == last_pos);
            @(negedge clock_i);
            acc = in_valid_i && in_ready_o;
            if (acc) k++;
        end
        if (k < L) chk("load_timeout", k, L);
        @(posedge clock_i); #1;
        in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0;
        chk("err_end", 32'(err_o), 32'(last_pos != L-1));
        chk("start_state", {30'd0, amns_start_o, in_ready_o}, 32'b10);
    endtask

    task automatic drain(input int rdy);
        int got = 0, g = 0;
        logic [16:0] e;
        while (got < NS && g < 2000) begin
            @(posedge clock_i); #1; g++;
            out_ready_i = $urandom_range(99) < rdy;
            @(negedge clock_i);
            if (out_valid_o && out_ready_i) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data_o), 32'(e));
                chk("out_last", 32'(out_last_o), 32'(got == NS-1));
                got++;
            end
        end
        if (got < NS) chk("drain_timeout", got, NS);
        @(posedge clock_i); #1;
        out_ready_i = 1'b0;
        chk("idle_after", {30'd0, busy_o, out_valid_o}, 32'd0);
    endtask

    task automatic run_op(input op_t o, input int id);
        load(o.last_pos, o.vstall, o.base);
        if (o.dis) amns_done_i = 1'b1;
        for (int d = 1; d <= o.dly; d++) begin
            @(posedge clock_i); #1;
            amns_done_i = 1'b0;
            chk("wait_idle", {30'd0, in_ready_o, bram_en_o}, 32'd0);
        end
        for (int j = 0; j < NS; j++) begin
            mem[j] = 17'h1F000 + 17'(id*32 + j);
            exp_q.push_back(mem[j]);
        end
        amns_done_i = 1'b1;
        @(posedge clock_i); #1;
        amns_done_i = 1'b0;
        chk("cycles", cycles_o, CC ? 32'(o.dly) : 32'd0);
        drain(o.rdy);
        chk("cycles_hold", cycles_o, CC ? 32'(o.dly) : 32'd0);
        chk("starts", start_n, 1);
        chk("writes", wr_n, L);
        chk("write_addr_data", wr_bad, 0);
        chk("outstanding_le2", 32'(max_occ <= 2), 1);
    endtask

    task automatic rst_now(input string nm);
        #2 reset_i = 1'b1;
        #1;
        chk({nm, "_flags"}, {24'd0, busy_o, in_ready_o, amns_start_o, out_valid_o, out_last_o, err_o, bram_en_o, bram_we_o}, 32'h40);
        chk({nm, "_data"}, {15'd0, out_data_o} | {15'd0, bram_din_o} | 32'(bram_addr_o) | cycles_o, 32'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        exp_q.delete();
        start_n = 0;
        repeat (10) @(posedge clock_i);
        #1;
        chk({nm, "_nostart"}, {start_n[30:0], busy_o}, 32'd0);
    endtask

    op_t ops [5];

    initial begin
        ops[0] = '{64, 0, 100, 37, 1'b0, 100};
        ops[1] = '{64, 0, 30, 5, 1'b0, 200};
        ops[2] = '{10, 0, 100, 3, 1'b0, 300};
        ops[3] = '{64, 30, 50, 1, 1'b1, 400};
        ops[4] = '{-1, 10, 70, 2, 1'b0, 500};
        #2 reset_i = 1'b1;
        #1;
        chk("reset_flags", {24'd0, busy_o, in_ready_o, amns_start_o, out_valid_o, out_last_o, err_o, bram_en_o, bram_we_o}, 32'h40);
        chk("reset_cycles", cycles_o, 32'd0);
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) run_op(ops[i], i);
        load(5, 0, 600);
        repeat (3) begin @(posedge clock_i); #1; end
        rst_now("reset_wait");
        load(64, 0, 700);
        @(posedge clock_i); #1;
        for (int j = 0; j < NS; j++) mem[j] = 17'h1F000 + 17'(j);
        amns_done_i = 1'b1;
        @(posedge clock_i); #1;
        amns_done_i = 1'b0;
        repeat (6) begin @(posedge clock_i); #1; end
        chk("drain_fifo_full", {30'd0, out_valid_o, busy_o}, 32'b11);
        rst_now("reset_drain");
        run_op(ops[0], 7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/amns_bram_loader.md
Name: amns_bram_loader

Overview:
- Host-side stream bridge that sits directly upstream and downstream of the AMNS multiplier top.
- Accepts a 17-bit operand stream and writes it into the shared bridge BRAM through BRAM port A. The multiplier top owns port B.
- Pulses the multiplier start, waits for done, then reads the N*s result words back from the BRAM and emits them as a 17-bit output stream with backpressure.

Parameters:
- s, 4, number of 17-bit sections per coefficient.
- N, 5, number of polynomial coefficients.
- RES_BASE, 0, BRAM word address of result word 0.
- ADDR_W, $clog2(4*N*s), BRAM address width (localparam).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  reset, asynchronous, active-high.
- in_data_i  in  17  operand word.
- in_valid_i  in  1  operand word valid.
- in_last_i  in  1  host marks final operand word.
- in_ready_o  out  1  loader accepts operand word.
- out_data_o  out  17  result word.
- out_valid_o  out  1  result word valid.
- out_last_o  out  1  final result word.
- out_ready_i  in  1  host accepts result word.
- bram_en_o  out  1  port A enable.
- bram_we_o  out  1  port A write enable.
- bram_addr_o  out  ADDR_W  port A word address.
- bram_din_o  out  17  port A write data.
- bram_dout_i  in  17  port A read data, valid 1 cycle after an enabled read.
- amns_start_o  out  1  one-cycle start pulse to the multiplier top.
- amns_done_i  in  1  multiplier top done pulse.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky framing error.
- cycles_o  out  32  multiplication cycle count (optional feature).

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation):
  - State goes to IDLE; all counters and the FIFO are cleared.
  - All outputs are 0, except in_ready_o, which is 1.
  - No start pulse is emitted after reset.
- Operand layout:
  - L = N + 3*N*s words (65 at default parameters), written to contiguous addresses 0..L-1 in arrival order.
  - Order is M'0 (N words), M (N*s), A (N*s), B (N*s).
- IDLE:
  - in_ready_o=1.
  - An accepted word (in_valid_i & in_ready_o) is written at address 0, word counter wc=1, and the state goes to LOAD. err_o clears on this same acceptance.
- LOAD:
  - in_ready_o=1. Each accepted word is written the same cycle: bram_en_o=bram_we_o=1, bram_addr_o=wc, bram_din_o=in_data_i. wc then increments.
  - Framing: in_last_i must be high exactly on word L-1. in_last_i high earlier, or low on word L-1, sets err_o. Loading always continues to L words; in_last_i never terminates it.
  - After word L-1 is accepted, go to START.
- START: amns_start_o=1 for exactly one cycle, in_ready_o=0, then go to WAIT.
- WAIT:
  - Port A is idle; in_ready_o=0.
  - amns_done_i high moves the state to DRAIN. A done arriving in the START cycle is ignored.
- DRAIN:
  - Issues reads at addresses RES_BASE+rc for rc=0..N*s-1, with bram_we_o=0.
  - Returned data enters a 2-entry FIFO one cycle after each read.
  - A read issues only when FIFO occupancy plus in-flight reads is less than 2. No word is ever dropped or duplicated under any out_ready_i pattern.
  - out_valid_o is high whenever the FIFO is non-empty; the head word leaves when out_valid_o & out_ready_i.
  - out_last_o is high with result word N*s-1.
  - When the last word is accepted, go to IDLE in the next cycle. Back-to-back operations are allowed.
- Simultaneous events:
  - FIFO push and pop in the same cycle keep the occupancy unchanged.
  - in_valid_i is ignored outside IDLE/LOAD.

Optional Feature:
- AMNS_LOADER_CYCLE_COUNT_EN:
  - Defined: cycles_o is a 32-bit counter, cleared in the START cycle and incremented in every WAIT cycle. It holds its value until the next START. It saturates at 2^32-1.
  - Undefined: cycles_o is constant 0 and no counter logic is synthesised.

Test Plan:
- Nominal load, default parameters: stream 65 words with value 100+k and in_last_i on k=64, no stalls -> 65 writes at addresses 0..64 with din 100..164; amns_start_o high 1 cycle; err_o=0.
- Drain with model BRAM: model RES words 0x1F000+j at RES_BASE=0 and pulse amns_done_i -> 20 words 0x1F000..0x1F013 out in order, out_last_o on the 20th, busy_o low afterwards.
- Output backpressure: out_ready_i random at 30% during DRAIN -> identical 20-word sequence, never more than 2 reads outstanding, no loss or duplicate.
- Framing error: in_last_i on word 10 and low on word 64 -> err_o=1 from word 10 onward, still exactly 65 writes and one start; err_o clears on the next operation's first word.
- Reset mid-operation: assert reset_i asynchronously in WAIT and in mid-DRAIN -> outputs 0 immediately, in_ready_o=1, no start pulse; a fresh full operation afterwards passes.
- With AMNS_LOADER_CYCLE_COUNT_EN: amns_done_i 37 cycles after the start pulse -> cycles_o=37, held through DRAIN. Without the macro -> cycles_o=0 throughout.
